// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: MIPS opcode/funct
// constants, the fetch FSM state type and a jr decode helper.
package fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_JR = 6'd8;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_START = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;

  function automatic logic is_jr(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) && (instr[5:0] == FUNCT_JR);
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-fetch-address selection for the held instruction:
// jr > jump > taken branch > sequential.
module fetch_unit_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] rs_data_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic        zero_i,
  output logic [31:0] next_pc_o
);

  logic        taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // instr[26] distinguishes bne from beq, flipping the sense of zero.
  assign taken         = branch_i & (zero_i ^ instr_i[26]);
  assign branch_target = pc_plus4_i + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
  assign jump_target   = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};

  always_comb begin
    // NOTE: assigning a default before the priority chain keeps every path
    // driven, so no latch is inferred.
    next_pc_o = pc_plus4_i;
    if (is_jr(instr_i)) begin
      next_pc_o = rs_data_i;
    end else if (jump_i) begin
      next_pc_o = jump_target;
    end else if (taken) begin
      next_pc_o = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: START/REQ/HOLD handshake with instruction memory.
// Optional macro FETCH_ALIGN_CHECK_EN enables a sticky misaligned-jr flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] rsData,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        alignErr
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic [31:0]  consume_pc;
  logic         consume;

  assign pc_plus4 = pc_q + 32'd4;
  assign consume  = (state_q == ST_HOLD) && !stall;

  fetch_unit_next_pc u_next_pc (
    .instr_i    (instr_q),
    .pc_plus4_i (pc_plus4),
    .rs_data_i  (rsData),
    .branch_i   (branch),
    .jump_i     (jump),
    .zero_i     (zero),
    .next_pc_o  (next_pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;
  logic jr_misaligned;

  assign jr_misaligned = is_jr(instr_q) && (rsData[1:0] != 2'b00);
  assign consume_pc    = is_jr(instr_q) ? {next_pc[31:2], 2'b00} : next_pc;
  assign align_err_d   = align_err_q | (consume && jr_misaligned);

  always_ff @(posedge clk) begin
    if (rst) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign alignErr = align_err_q;
`else
  assign consume_pc = next_pc;
  assign alignErr   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_START: state_d = ST_REQ;
      ST_REQ: begin
        if (imemAck) begin
          instr_d = imemRdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (consume) begin
          pc_d    = consume_pc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_START;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imemReq    = (state_q == ST_REQ);
  assign instrValid = (state_q == ST_HOLD);
  assign imemAddr   = pc_q;
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign instr      = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed control-flow cases followed by
// randomized fetch traffic checked against a behavioural next-pc model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] rsData = '0;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        alignErr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemAck    (imemAck),
    .imemRdata  (imemRdata),
    .stall      (stall),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .rsData     (rsData),
    .instr      (instr),
    .instrValid (instrValid),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .alignErr   (alignErr)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } hold_exp_t;

  hold_exp_t   hold_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic        exp_align = 1'b0;
  logic        rst_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next fetch address from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] w,
                                             input logic br, input logic jp, input logic zr,
                                             input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = cur_pc + 32'd4;
    if (w[31:26] == 6'd0 && w[5:0] == 6'd8) begin
`ifdef FETCH_ALIGN_CHECK_EN
      return rs & 32'hFFFF_FFFC;
`else
      return rs;
`endif
    end
    if (jp) return (seq & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
    if (br && ((w[31:26] == 6'd4 && zr) || (w[31:26] == 6'd5 && !zr))) begin
      off = int'($signed(w[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  function automatic logic model_align_fault(input logic [31:0] w, input logic [31:0] rs);
`ifdef FETCH_ALIGN_CHECK_EN
    return (w[31:26] == 6'd0 && w[5:0] == 6'd8) && (rs[1:0] != 2'b00);
`else
    return 1'b0 && (w[0] ^ rs[0]);
`endif
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] mk_j(input logic [25:0] tgt);
    return {OP_J, tgt};
  endfunction

  function automatic logic [31:0] mk_jr();
    return {OP_RTYPE, 5'd31, 15'd0, FUNCT_JR};
  endfunction

  always @(posedge clk) rst_seen <= rst;

  // Monitor: compares DUT outputs against scoreboard entries on the falling edge.
  logic      mon_prev_req = 1'b0;
  logic      mon_prev_valid = 1'b0;
  logic [31:0] mon_addr = '0;
  hold_exp_t mon_held = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check("rst_imemReq", 32'(imemReq), 32'd0);
        check("rst_instrValid", 32'(instrValid), 32'd0);
        check("rst_alignErr", 32'(alignErr), 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 32'd0);
        mon_prev_req   = 1'b0;
        mon_prev_valid = 1'b0;
      end else begin
        check("req_valid_exclusive", 32'(imemReq & instrValid), 32'd0);
        if (imemReq && !mon_prev_req) begin
          if (addr_q.size() == 0) begin
            check("addr_q_underflow", 32'(addr_q.size()), 32'd1);
          end else begin
            mon_addr = addr_q.pop_front();
            check("fetch_addr", imemAddr, mon_addr);
            check("align_err", 32'(alignErr), 32'(exp_align));
          end
        end else if (imemReq) begin
          check("addr_stable", imemAddr, mon_addr);
        end
        if (instrValid && !mon_prev_valid) begin
          if (hold_q.size() == 0) begin
            check("hold_q_underflow", 32'(hold_q.size()), 32'd1);
          end else begin
            mon_held = hold_q.pop_front();
            check("hold_instr", instr, mon_held.word);
            check("hold_pc", pc, mon_held.pc);
            check("hold_pcPlus4", pcPlus4, mon_held.pc + 32'd4);
          end
        end else if (instrValid) begin
          check("stall_instr", instr, mon_held.word);
          check("stall_pc", pc, mon_held.pc);
        end
        mon_prev_req   = imemReq;
        mon_prev_valid = instrValid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Don't-care inputs get random values whenever they must be ignored.
  task automatic scramble();
    branch    = 1'($urandom);
    jump      = 1'($urandom);
    zero      = 1'($urandom);
    rsData    = $urandom;
    stall     = 1'($urandom);
    imemRdata = $urandom;
  endtask

  task automatic wait_req(output logic ok);
    int n = 0;
    while (!imemReq && n < 20) begin
      scramble();
      imemAck = 1'b0;
      step();
      n++;
    end
    ok = imemReq;
    if (!ok) check("req_timeout", 32'(imemReq), 32'd1);
  endtask

  task automatic fetch_one(input logic [31:0] word, input logic br, input logic jp,
                           input logic zr, input logic [31:0] rs, input int dly, input int nstall);
    logic [31:0] nxt;
    logic        ok;
    wait_req(ok);
    if (!ok) return;
    repeat (dly) begin
      scramble();
      imemAck = 1'b0;
      step();
    end
    scramble();
    imemAck   = 1'b1;
    imemRdata = word;
    hold_q.push_back('{pc: exp_pc, word: word});
    step();
    repeat (nstall) begin
      scramble();
      stall   = 1'b1;
      imemAck = 1'($urandom);
      step();
    end
    scramble();
    imemAck = 1'($urandom);
    stall   = 1'b0;
    branch  = br;
    jump    = jp;
    zero    = zr;
    rsData  = rs;
    nxt     = model_next(exp_pc, word, br, jp, zr, rs);
    if (model_align_fault(word, rs)) exp_align = 1'b1;
    addr_q.push_back(nxt);
    exp_pc = nxt;
    step();
    imemAck = 1'b0;
    scramble();
  endtask

  // Reset in the middle of a request, with an ack that arrives too late.
  task automatic reset_mid_req();
    logic ok;
    wait_req(ok);
    if (!ok) return;
    rst       = 1'b1;
    imemAck   = 1'b1;
    imemRdata = $urandom;
    step();
    exp_pc    = RESET_PC;
    exp_align = 1'b0;
    addr_q.push_back(RESET_PC);
    rst     = 1'b0;
    imemAck = 1'b1;
    step();
    imemAck = 1'b0;
    check("stray_ack_no_valid", 32'(instrValid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  seq_ops[4];
    logic [31:0] w;
    logic [31:0] rs;
    logic        br;
    logic        jp;
    logic        zr;
    int          kind;
    seq_ops = '{OP_ADDI, OP_ORI, OP_LW, OP_SW};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_pc = RESET_PC;
    addr_q.push_back(RESET_PC);

    // Sequential fetch 0, 4, 8.
    fetch_one(mk_i(OP_ADDI, 16'h0001), 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
    fetch_one(mk_i(OP_ADDI, 16'h0002), 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
    fetch_one(mk_i(OP_ADDI, 16'h0003), 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
    // Backward beq at 0x10 loops to itself; bne at 0x20 with zero=1 falls through.
    fetch_one(mk_jr(), 1'b0, 1'b0, 1'b0, 32'h0000_0010, 0, 0);
    fetch_one(mk_i(OP_BEQ, 16'hFFFF), 1'b1, 1'b0, 1'b1, 32'h0, 0, 0);
    fetch_one(mk_jr(), 1'b0, 1'b0, 1'b0, 32'h0000_0020, 0, 0);
    fetch_one(mk_i(OP_BNE, 16'h0040), 1'b1, 1'b0, 1'b1, 32'h0, 0, 0);
    // Jump region and jr targets, including a misaligned one.
    fetch_one(mk_jr(), 1'b0, 1'b0, 1'b0, 32'h3000_0000, 0, 0);
    fetch_one(mk_j(26'h100), 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    fetch_one(mk_jr(), 1'b0, 1'b0, 1'b0, 32'h0000_0044, 0, 0);
    fetch_one(mk_jr(), 1'b0, 1'b0, 1'b0, 32'h0000_0046, 0, 0);
    // Long stall in HOLD, slow memory in REQ.
    fetch_one(mk_i(OP_ADDI, 16'h0004), 1'b0, 1'b0, 1'b0, 32'h0, 3, 5);
    // Wrap at the top of the address space, and jr winning over jump.
    fetch_one(mk_jr(), 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 0);
    fetch_one(mk_i(OP_ORI, 16'h0005), 1'b0, 1'b0, 1'b0, 32'h0, 1, 0);
    fetch_one(mk_jr(), 1'b1, 1'b1, 1'b1, 32'h0000_0200, 0, 1);
    fetch_one(mk_i(OP_BEQ, 16'h0010), 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    reset_mid_req();

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      zr   = 1'($urandom);
      rs   = $urandom;
      br   = 1'b0;
      jp   = 1'b0;
      case (kind)
        3: begin w = mk_i(OP_BEQ, 16'($urandom)); br = 1'b1; end
        4: begin w = mk_i(OP_BNE, 16'($urandom)); br = 1'b1; end
        5: begin w = mk_j(26'($urandom)); jp = 1'b1; end
        6: begin
          w  = mk_jr();
          jp = 1'($urandom);
          if ($urandom_range(0, 3) != 0) rs = rs & 32'hFFFF_FFFC;
        end
        default: w = mk_i(seq_ops[$urandom_range(0, 3)], 16'($urandom));
      endcase
      fetch_one(w, br, jp, zr, rs, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      if ($urandom_range(0, 39) == 0) reset_mid_req();
    end

    repeat (4) step();
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    check("hold_q_drained", 32'(hold_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
